gray_ctrl: RTL

Two-requester sequencing controller for the 3-bit Gray counter. It arbitrates run/clear jobs between requesters A and B with round-robin priority, and drives the counter's enable and reset for an exact number of cycles. It reports per-job completion and whether the counter wrapped during the job. It sits between the control logic and the counter's En/Reset/Output pins.

---
 rtl/gray_ctrl_if.sv | 44 ++++
 rtl/gray_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/gray_ctrl_if.sv
// ============================================================================
// gray_ctrl_if : job request/ack and counter pin bundle for gray_ctrl
// Optional Hold signal under GRAY_CTRL_HOLD_EN.  Rev 1.0
// ============================================================================
`default_nettype none

interface gray_ctrl_if;
  logic       Req_A;
  logic       Req_B;
  logic [3:0] Steps_A;
  logic [3:0] Steps_B;
  logic       Ack_A;
  logic       Ack_B;
  logic       Done_A;
  logic       Done_B;
  logic       Wrap;
  logic       Busy;
  logic       Cnt_En;
  logic       Cnt_Reset;
  logic [2:0] Cnt_Value;
`ifdef GRAY_CTRL_HOLD_EN
  logic       Hold;

  modport master (
    output Req_A, Req_B, Steps_A, Steps_B, Cnt_Value, Hold,
    input  Ack_A, Ack_B, Done_A, Done_B, Wrap, Busy, Cnt_En, Cnt_Reset
  );
  modport slave (
    input  Req_A, Req_B, Steps_A, Steps_B, Cnt_Value, Hold,
    output Ack_A, Ack_B, Done_A, Done_B, Wrap, Busy, Cnt_En, Cnt_Reset
  );
`else
  modport master (
    output Req_A, Req_B, Steps_A, Steps_B, Cnt_Value,
    input  Ack_A, Ack_B, Done_A, Done_B, Wrap, Busy, Cnt_En, Cnt_Reset
  );
  modport slave (
    input  Req_A, Req_B, Steps_A, Steps_B, Cnt_Value,
    output Ack_A, Ack_B, Done_A, Done_B, Wrap, Busy, Cnt_En, Cnt_Reset
  );
`endif
endinterface

`default_nettype wire

// File: rtl/gray_ctrl.sv
// ============================================================================
// gray_ctrl : round-robin two-requester run/clear sequencer for a 3-bit Gray
// counter; optional RUN stall via GRAY_CTRL_HOLD_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module gray_ctrl (
  input  wire logic  Clk,
  input  wire logic  Reset,
  gray_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [2:0] WRAP_CODE = 3'b100;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] remaining;
  logic       owner_b;
  logic       last_b;
  logic       wrap_flag;
  logic       ack_a;
  logic       ack_b;
  logic       hold;
  logic       req_any;
  logic       grant_b;
  logic [3:0] grant_steps;

`ifdef GRAY_CTRL_HOLD_EN
  assign hold = bus.Hold;
`else
  assign hold = 1'b0;
`endif

  // On a tie, B wins only if A was the last one granted.
  assign req_any     = bus.Req_A | bus.Req_B;
  assign grant_b     = bus.Req_B & (~bus.Req_A | ~last_b);
  assign grant_steps = grant_b ? bus.Steps_B : bus.Steps_A;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          state_nxt = (grant_steps != 4'd0) ? S_RUN : S_CLEAR;
        end
      end
      S_RUN: begin
        if (!hold && remaining == 4'd1) begin
          state_nxt = S_DONE;
        end
      end
      S_CLEAR: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      remaining <= 4'd0;
      owner_b   <= 1'b0;
      last_b    <= 1'b1;
      wrap_flag <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (state == S_IDLE && req_any) begin
        owner_b   <= grant_b;
        last_b    <= grant_b;
        remaining <= grant_steps;
        wrap_flag <= 1'b0;
        ack_a     <= ~grant_b;
        ack_b     <= grant_b;
      end
      if (state == S_RUN && !hold) begin
        remaining <= remaining - 4'd1;
        if (bus.Cnt_Value == WRAP_CODE) begin
          wrap_flag <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.Ack_A     = ack_a;
    bus.Ack_B     = ack_b;
    bus.Done_A    = (state == S_DONE) & ~owner_b;
    bus.Done_B    = (state == S_DONE) & owner_b;
    bus.Wrap      = (state == S_DONE) & wrap_flag;
    bus.Busy      = (state != S_IDLE);
    bus.Cnt_En    = (state == S_RUN) & ~hold;
    bus.Cnt_Reset = Reset | (state == S_CLEAR);
  end

endmodule

`default_nettype wire
